// File: rtl/frame_rate_ctrl.sv
// Frame-rate measurement controller: detects frame wraps on the FIFO y stream,
// counts frames over fixed gate windows and drives the debug/LED bus and alarm.
module frame_rate_ctrl #(
  parameter int unsigned GATE_CYCLES = 125000000,
  parameter int unsigned YW          = 12
) (
  input  logic          clk125m,
  input  logic          reset,
  input  logic          enable,
  input  logic          fifo_wr_en,
  input  logic [YW-1:0] y_din,
  input  logic [1:0]    sw,
  input  logic [7:0]    dipsw,
  output logic [7:0]    signal,
  output logic          frame,
  output logic [7:0]    rate,
  output logic          rate_valid,
  output logic          over,
  output logic [YW-1:0] lines,
  output logic          alarm
);

  localparam int unsigned GW = 27;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARM     = 2'b01,
    MEASURE = 2'b10,
    LATCH   = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic [YW-1:0] y_last_q, y_max_q, lines_q;
  logic          have_prev_q, frame_q;
  logic [GW-1:0] gate_q, gate_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    rate_q, rate_d;
  logic          over_q, over_d;
  logic          alarm_q, alarm_d;
  logic          bnd;

  // A wrap is a strictly smaller y than the previous write; equal y is not a wrap.
  assign bnd = fifo_wr_en & have_prev_q & (y_din < y_last_q);

  always_ff @(posedge clk125m or posedge reset) begin
    if (reset) begin
      y_last_q    <= '0;
      y_max_q     <= '0;
      lines_q     <= '0;
      have_prev_q <= 1'b0;
      frame_q     <= 1'b0;
    end else begin
      if (fifo_wr_en) begin
        y_last_q    <= y_din;
        have_prev_q <= 1'b1;
      end
      if (bnd) begin
        frame_q <= ~frame_q;
        lines_q <= y_max_q + YW'(1);
        y_max_q <= y_din;
      end else if (fifo_wr_en && (y_din > y_max_q)) begin
        y_max_q <= y_din;
      end
    end
  end

  always_ff @(posedge clk125m or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gate_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      rate_q  <= '0;
      over_q  <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gate_q  <= gate_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      rate_q  <= rate_d;
      over_q  <= over_d;
      alarm_q <= alarm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gate_d  = gate_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    rate_d  = rate_q;
    over_d  = over_q;
    alarm_d = alarm_q;
    unique case (state_q)
      IDLE: begin
        gate_d = '0;
        cnt_d  = '0;
        ovf_d  = 1'b0;
        if (enable) state_d = ARM;
      end
      ARM: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (bnd) begin
          state_d = MEASURE;
          gate_d  = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      MEASURE: begin
        if (!enable) begin
          state_d = IDLE;
          gate_d  = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end else begin
          gate_d = gate_q + GW'(1);
          if (bnd) begin
            if (cnt_q == 8'hFF) ovf_d = 1'b1;
            else                cnt_d = cnt_q + 8'd1;
          end
          if (gate_q == GATE_LAST) state_d = LATCH;
        end
      end
      LATCH: begin
        rate_d  = cnt_q;
        over_d  = ovf_q;
        alarm_d = (cnt_q < dipsw);
        gate_d  = '0;
        // A wrap seen during LATCH opens the next window's count.
        cnt_d   = bnd ? 8'd1 : 8'd0;
        ovf_d   = 1'b0;
        state_d = enable ? MEASURE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    signal = '0;
    unique case (sw)
      2'b00: signal = rate_q;
      2'b01: signal = {over_q, alarm_q, state_q, 4'b0000};
      2'b10: signal = lines_q[7:0];
      2'b11: signal = 8'(lines_q >> 8);
      default: signal = '0;
    endcase
  end

  assign rate_valid = (state_q == LATCH);
  assign frame      = frame_q;
  assign rate       = rate_q;
  assign over       = over_q;
  assign alarm      = alarm_q;
  assign lines      = lines_q;

endmodule
